// File: rtl/beamform_pkg.sv
// Shared encodings and defaults for the beamforming transmit path and its UART command decoder.
// Holds only declarations and a constant-evaluation helper; there is no logic or timing here.
package beamform_pkg;

    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_DELAY_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FIRE     = 3'd1,
        GUARD    = 3'd2,
        LISTEN   = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_delay_channel.sv
// Per-channel pulse window comparator: high while delay <= cnt < delay + PULSE_CYCLES.
// Purely combinational; the parent registers the result, so it adds no latency and has no backpressure.
module tx_delay_channel #(
    parameter int DELAY_W      = 6,
    parameter int CNT_W        = 9,
    parameter int PULSE_CYCLES = 4
) (
    input  logic [CNT_W-1:0]   cnt,
    input  logic [DELAY_W-1:0] delay,
    input  logic               fire_en,
    output logic               pulse
);

    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] end_cnt;

    assign start_cnt = CNT_W'(delay);
    assign end_cnt   = start_cnt + CNT_W'(PULSE_CYCLES);
    assign pulse     = fire_en && (cnt >= start_cnt) && (cnt < end_cnt);

endmodule

// File: rtl/beamform_transmit_fsm.sv
// Beam-steered multi-channel transmit sequencer: loads per-channel delays, fires, guards, listens, waits for mem_clear.
// Pulses are registered and appear on the first FIRE cycle; the next line is held off until mem_clear in WAIT_CLR.
module beamform_transmit_fsm
    import beamform_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int DELAY_W       = DEF_DELAY_W,
    parameter int PULSE_CYCLES  = 4,
    parameter int GUARD_CYCLES  = 2,
    parameter int LISTEN_CYCLES = 32,
    parameter int NUM_LINES     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_transmit,
    input  logic [7:0]                       received_data,
    input  logic                             new_received_data,
    input  logic                             mem_clear,
    output logic [NUM_CH-1:0]                ultrasound_pulses,
    output logic                             afe_switch,
    output logic                             transmit_in_progress,
    output logic                             busy,
    output logic [$clog2(NUM_LINES+1)-1:0]   line_index,
    output logic                             frame_done
);

    localparam int CNT_W  = DELAY_W + $clog2(PULSE_CYCLES) + 1;
    localparam int TMR_W  = $clog2(max_int(GUARD_CYCLES, LISTEN_CYCLES) + 1);
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LINE_W = $clog2(NUM_LINES + 1);

    state_t             state;
    state_t             state_nxt;
    logic [DELAY_W-1:0] delay_q   [NUM_CH];
    logic [DELAY_W-1:0] delay_eff [NUM_CH];
    logic [DELAY_W-1:0] max_delay;
    logic [PTR_W-1:0]   cfg_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   fire_len;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_nxt;
    logic [NUM_CH-1:0]  pulse_nxt;
    logic               fire_en;
    logic               cfg_wr;
    logic               last_line;

    assign cfg_wr    = (state == IDLE) && new_received_data;
    assign last_line = (line_index == LINE_W'(NUM_LINES - 1));
    assign fire_en   = (state_nxt == FIRE);

    // A byte arriving together with start_transmit must already shape this frame,
    // so the comparators and the max tree see the write forwarded ahead of the register.
    always_comb begin
        max_delay = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            delay_eff[i] = (cfg_wr && (cfg_ptr == PTR_W'(i))) ? received_data[DELAY_W-1:0] : delay_q[i];
            if (delay_eff[i] > max_delay) begin
                max_delay = delay_eff[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_transmit) state_nxt = FIRE;
            FIRE:     if (cnt == fire_len - 1'b1) state_nxt = GUARD;
            GUARD:    if (tmr == TMR_W'(GUARD_CYCLES - 1)) state_nxt = LISTEN;
            LISTEN:   if (tmr == TMR_W'(LISTEN_CYCLES - 1)) state_nxt = WAIT_CLR;
            WAIT_CLR: if (mem_clear) state_nxt = last_line ? IDLE : FIRE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        afe_switch           = (state == LISTEN) || (state == WAIT_CLR);
        transmit_in_progress = (state == FIRE) || (state == GUARD);
        busy                 = (state != IDLE);
        frame_done           = (state == WAIT_CLR) && mem_clear && last_line;
    end

    // Counters are evaluated one cycle ahead so the pulse register lines up with the FIRE cycle it describes.
    always_comb begin
        cnt_nxt = '0;
        tmr_nxt = '0;
        if ((state == FIRE) && (state_nxt == FIRE)) begin
            cnt_nxt = cnt + 1'b1;
        end
        if (((state == GUARD) || (state == LISTEN)) && (state_nxt == state)) begin
            tmr_nxt = tmr + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tx_delay_channel #(
            .DELAY_W      (DELAY_W),
            .CNT_W        (CNT_W),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_ch (
            .cnt     (cnt_nxt),
            .delay   (delay_eff[g]),
            .fire_en (fire_en),
            .pulse   (pulse_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt               <= '0;
            tmr               <= '0;
            fire_len          <= '0;
            cfg_ptr           <= '0;
            line_index        <= '0;
            ultrasound_pulses <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            cnt               <= cnt_nxt;
            tmr               <= tmr_nxt;
            ultrasound_pulses <= pulse_nxt;
            if (cfg_wr) begin
                delay_q[cfg_ptr] <= received_data[DELAY_W-1:0];
            end
            if ((state == IDLE) && start_transmit) begin
                cfg_ptr    <= '0;
                line_index <= '0;
                fire_len   <= CNT_W'(max_delay) + CNT_W'(PULSE_CYCLES);
            end else if (cfg_wr) begin
                cfg_ptr <= (cfg_ptr == PTR_W'(NUM_CH - 1)) ? '0 : cfg_ptr + 1'b1;
            end
            if ((state == WAIT_CLR) && mem_clear && !last_line) begin
                line_index <= line_index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beamform_transmit_fsm.sv
// Scoreboarded bench for beamform_transmit_fsm: expected line timing is queued at stimulus and checked per fired line.
module tb_beamform_transmit_fsm;

    localparam int NUM_CH = 8;
    localparam int P      = 4;
    localparam int G      = 2;
    localparam int L      = 32;
    localparam int NL     = 5;

    typedef struct {
        int rise [NUM_CH];
        int flen;
        int line;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start_transmit;
    logic [7:0]        received_data;
    logic              new_received_data;
    logic              mem_clear;
    logic [NUM_CH-1:0] ultrasound_pulses;
    logic              afe_switch;
    logic              transmit_in_progress;
    logic              busy;
    logic [2:0]        line_index;
    logic              frame_done;

    int   checks;
    int   errors;
    int   mdelay [NUM_CH];
    int   mptr;
    exp_t sb_q [$];

    beamform_transmit_fsm dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_transmit       (start_transmit),
        .received_data        (received_data),
        .new_received_data    (new_received_data),
        .mem_clear            (mem_clear),
        .ultrasound_pulses    (ultrasound_pulses),
        .afe_switch           (afe_switch),
        .transmit_in_progress (transmit_in_progress),
        .busy                 (busy),
        .line_index           (line_index),
        .frame_done           (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(afe_switch && (|ultrasound_pulses)))
        else $error("FAIL overlap: afe_switch=1 with pulses=%h, required no overlap", ultrasound_pulses);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int model_flen();
        int m = 0;
        for (int i = 0; i < NUM_CH; i++) if (mdelay[i] > m) m = mdelay[i];
        return m + P;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) mdelay[i] = 0;
        mptr = 0;
        sb_q.delete();
    endtask

    task automatic push_line(input int line);
        exp_t e;
        e.rise = mdelay;
        e.flen = model_flen();
        e.line = line;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data     = b;
        new_received_data = 1'b1;
        mdelay[mptr]      = int'(b[5:0]);
        mptr              = (mptr + 1) % NUM_CH;
        @(posedge clk);
        #1 new_received_data = 1'b0;
    endtask

    task automatic start_frame(input bit with_byte, input logic [7:0] b);
        if (with_byte) begin
            received_data     = b;
            new_received_data = 1'b1;
            mdelay[mptr]      = int'(b[5:0]);
        end
        start_transmit = 1'b1;
        mptr = 0;
        push_line(0);
        @(posedge clk);
        #1;
        start_transmit    = 1'b0;
        new_received_data = 1'b0;
    endtask

    // Records one line from its first FIRE cycle to its first WAIT_CLR cycle; optional injections at cycle k.
    task automatic check_line(input int inj_start, input int inj_mc, input int inj_byte);
        exp_t       e;
        int         first [NUM_CH];
        int         hi [NUM_CH];
        int         tip_len, afe_rise, overlap, w, waitc;
        bit         tip_done, tip_again, afe_drop;
        logic [2:0] li_exp;
        waitc = 0;
        @(negedge clk);
        while (!transmit_in_progress && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (!transmit_in_progress) begin
            errors++;
            $display("FAIL line_start: transmit_in_progress=0 after %0d cycles, required 1", waitc);
            return;
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: line fired with queue size 0, required an expected entry");
            return;
        end
        e = sb_q.pop_front();
        w = e.flen + G + L;
        for (int i = 0; i < NUM_CH; i++) begin
            first[i] = -1;
            hi[i]    = 0;
        end
        tip_len = 0; afe_rise = -1; overlap = 0;
        tip_done = 1'b0; tip_again = 1'b0; afe_drop = 1'b0;
        for (int k = 0; k <= w; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ultrasound_pulses[i]) begin
                    if (first[i] < 0) first[i] = k;
                    hi[i]++;
                end
            end
            if (transmit_in_progress) begin
                if (tip_done) tip_again = 1'b1;
                else tip_len++;
            end else begin
                tip_done = 1'b1;
            end
            if (afe_switch && afe_rise < 0) afe_rise = k;
            if (!afe_switch && afe_rise >= 0) afe_drop = 1'b1;
            if (afe_switch && (|ultrasound_pulses)) overlap++;
            if (k == 0) begin
                li_exp = 3'(e.line);
                checks++;
                if (line_index !== li_exp) begin
                    errors++;
                    $display("FAIL line_index: got %0d, required %0d", line_index, li_exp);
                end
            end
            start_transmit    = (k == inj_start);
            mem_clear         = (k == inj_mc);
            new_received_data = (k == inj_byte);
            if (k == inj_byte) received_data = 8'h3F;
        end
        start_transmit = 1'b0; mem_clear = 1'b0; new_received_data = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (first[i] != e.rise[i]) begin
                errors++;
                $display("FAIL ch%0d_rise line %0d: got cycle %0d, required %0d", i, e.line, first[i], e.rise[i]);
            end
            checks++;
            if (hi[i] != P) begin
                errors++;
                $display("FAIL ch%0d_width line %0d: got %0d cycles, required %0d", i, e.line, hi[i], P);
            end
        end
        checks++;
        if (tip_len != e.flen + G || tip_again) begin
            errors++;
            $display("FAIL tip_len line %0d: got %0d (reasserted=%0d), required %0d", e.line, tip_len, tip_again, e.flen + G);
        end
        checks++;
        if (afe_rise != e.flen + G || afe_drop) begin
            errors++;
            $display("FAIL afe_rise line %0d: got cycle %0d (dropped=%0d), required %0d", e.line, afe_rise, afe_drop, e.flen + G);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL overlap_window line %0d: got %0d cycles, required 0", e.line, overlap);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait_clr line %0d: got %b, required 1", e.line, busy);
        end
    endtask

    // Pulses mem_clear about 700 ns into WAIT_CLR and checks frame_done on that cycle.
    task automatic clear_line(input int line_done, input bit last);
        repeat (70) @(posedge clk);
        #1 mem_clear = 1'b1;
        if (!last) push_line(line_done + 1);
        @(negedge clk);
        checks++;
        if (frame_done !== last) begin
            errors++;
            $display("FAIL frame_done line %0d: got %b, required %b", line_done, frame_done, last);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_clear line %0d: got %b, required 1", line_done, busy);
        end
        @(posedge clk);
        #1 mem_clear = 1'b0;
        if (last) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL frame_end: busy=%b frame_done=%b, required 0 0", busy, frame_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (ultrasound_pulses !== 8'h00 || afe_switch !== 1'b0 || transmit_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: pulses=%h afe=%b tip=%b, required 00 0 0", ultrasound_pulses, afe_switch, transmit_in_progress);
        end
        checks++;
        if (busy !== 1'b0 || line_index !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b line=%0d done=%b, required 0 0 0", busy, line_index, frame_done);
        end
    endtask

    task automatic test_default_profile();
        start_frame(1'b0, 8'h00);
        check_line(-1, -1, -1);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || transmit_in_progress !== 1'b0 || afe_switch !== 1'b1) begin
            errors++;
            $display("FAIL wait_clr_hold: busy=%b tip=%b afe=%b, required 1 0 1", busy, transmit_in_progress, afe_switch);
        end
        do_reset();
    endtask

    task automatic test_steered();
        for (int i = 0; i < NUM_CH; i++) send_byte(8'(i));
        start_frame(1'b0, 8'h00);
        check_line(-1, -1, -1);
        do_reset();
    endtask

    task automatic test_full_frame();
        logic [7:0] prof [NUM_CH] = '{8'd3, 8'd0, 8'd5, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
        for (int i = 0; i < NUM_CH; i++) send_byte(prof[i]);
        start_frame(1'b0, 8'h00);
        for (int l = 0; l < NL; l++) begin
            check_line(-1, -1, -1);
            clear_line(l, l == NL - 1);
        end
        do_reset();
    endtask

    task automatic test_ignored_events();
        int f;
        send_byte(8'hC5);
        send_byte(8'h02);
        send_byte(8'h09);
        start_frame(1'b0, 8'h00);
        f = model_flen();
        check_line(1, f + G + L - 1, f + G + 3);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || transmit_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL listen_memclr_ignored: busy=%b tip=%b, required 1 0", busy, transmit_in_progress);
        end
        clear_line(0, 1'b0);
        check_line(-1, -1, -1);
        do_reset();
    endtask

    task automatic test_ptr_wrap();
        logic [2:0] pexp;
        for (int i = 10; i <= 18; i++) send_byte(8'(i));
        pexp = 3'(mptr);
        checks++;
        if (dut.cfg_ptr !== pexp) begin
            errors++;
            $display("FAIL cfg_ptr_wrap: got %0d, required %0d", dut.cfg_ptr, pexp);
        end
        start_frame(1'b1, 8'd40);
        check_line(-1, -1, -1);
        do_reset();
    endtask

    task automatic test_reset_mid_fire();
        int waitc = 0;
        for (int i = 0; i < NUM_CH; i++) send_byte(8'(i));
        start_frame(1'b0, 8'h00);
        @(negedge clk);
        while (!ultrasound_pulses[3] && waitc < 30) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (!ultrasound_pulses[3]) begin
            errors++;
            $display("FAIL ch3_high_wait: ch3 stayed 0 for %0d cycles, required 1", waitc);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (ultrasound_pulses !== 8'h00 || afe_switch !== 1'b0 || busy !== 1'b0 || transmit_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL mid_fire_reset: pulses=%h afe=%b busy=%b tip=%b, required 00 0 0 0",
                     ultrasound_pulses, afe_switch, busy, transmit_in_progress);
        end
        start_frame(1'b0, 8'h00);
        check_line(-1, -1, -1);
        do_reset();
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        start_transmit    = 1'b0;
        received_data     = 8'h00;
        new_received_data = 1'b0;
        mem_clear         = 1'b0;
        model_clear();
        test_reset();
        test_default_profile();
        test_steered();
        test_full_frame();
        test_ignored_events();
        test_ptr_wrap();
        test_reset_mid_fire();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beamform_transmit_fsm.md
Name: beamform_transmit_fsm

Overview:
Parametrised successor to the single-line image transmit FSM. It fires NUM_CH ultrasound pulse channels with per-channel programmable transmit delays for beam steering and focusing, then switches the AFE to receive and listens for a fixed window. It then waits for the capture memory to be cleared before firing the next line, and repeats for NUM_LINES lines per frame. Sits between the UART byte receiver (which supplies the delay profile) and the pulser/AFE front-end pins.

Parameters:
NUM_CH, 8, number of transmit channels / width of ultrasound_pulses
DELAY_W, 6, bit width of each per-channel delay (cycles)
PULSE_CYCLES, 4, cycles each channel's pulse stays high (>=1)
GUARD_CYCLES, 2, dead time between last pulse falling and afe_switch rising (>=1)
LISTEN_CYCLES, 32, receive-window length in cycles (>=1)
NUM_LINES, 5, lines fired per start_transmit (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_transmit  in  1  one-cycle request to begin a frame; honoured only in IDLE
received_data  in  8  config byte from UART; low DELAY_W bits are a channel delay
new_received_data  in  1  one-cycle strobe qualifying received_data
mem_clear  in  1  one-cycle pulse: capture memory drained, next line may fire
ultrasound_pulses  out  NUM_CH  per-channel transmit pulse, registered
afe_switch  out  1  1 = AFE connected to receive path; 0 = protected during transmit
transmit_in_progress  out  1  high while in FIRE or GUARD
busy  out  1  high in every state except IDLE
line_index  out  $clog2(NUM_LINES+1)  current line number, 0-based
frame_done  out  1  one-cycle pulse when the last line's WAIT_CLR completes

Behaviour:
- Single clock domain. rst is synchronous, active-high: on the reset edge, state becomes IDLE and all outputs go to 0. All delay registers, the config pointer and all counters clear. Reset mid-frame aborts immediately; no pulse remains high after the reset edge.
- Config loading: in IDLE, each new_received_data strobe writes received_data[DELAY_W-1:0] into delay[cfg_ptr], then increments cfg_ptr, wrapping NUM_CH-1 -> 0. Upper bits are ignored. Strobes while busy are ignored and do not move cfg_ptr. start_transmit resets cfg_ptr to 0.
- Simultaneous start_transmit and new_received_data in IDLE: the byte is written first, then the frame starts using the updated profile.
- States: IDLE -> FIRE -> GUARD -> LISTEN -> WAIT_CLR -> (FIRE, or IDLE via frame_done).
- IDLE -> FIRE: on the edge that samples start_transmit=1. line_index <= 0. max_delay (combinational max over all delay[i]) is latched into fire_len = max_delay + PULSE_CYCLES. The fire counter is cleared to 0.
- FIRE: the counter increments every cycle. ultrasound_pulses[i] is registered high while delay[i] <= cnt < delay[i]+PULSE_CYCLES. A channel with delay 0 is therefore high on the first PULSE_CYCLES FIRE cycles. FIRE exits to GUARD when cnt == fire_len-1.
- Counter width is DELAY_W+$clog2(PULSE_CYCLES)+1, so there is no overflow.
- GUARD: lasts GUARD_CYCLES. Pulses are 0 and afe_switch is 0.
- LISTEN: afe_switch = 1 for LISTEN_CYCLES, then go to WAIT_CLR.
- WAIT_CLR: afe_switch stays 1; wait for mem_clear.
  - If line_index < NUM_LINES-1: increment line_index and go to FIRE. Delays and fire_len are unchanged within a frame.
  - Otherwise: pulse frame_done for one cycle and go to IDLE.
- mem_clear outside WAIT_CLR is ignored and is not remembered.
- start_transmit while busy is ignored.
- transmit_in_progress = (state==FIRE || state==GUARD). busy = (state!=IDLE). afe_switch is 0 in IDLE, FIRE and GUARD.
- Invariant: afe_switch and any ultrasound_pulses bit are never high in the same cycle.

Decomposition:
- Shared package beamform_pkg holds:
  - the state encoding constants (IDLE, FIRE, GUARD, LISTEN, WAIT_CLR);
  - the default NUM_CH/DELAY_W values shared with the UART command decoder.
- One sub-module is natural: tx_delay_channel. It holds a comparator slice per channel (inputs cnt, delay, fire_en; output pulse), instantiated NUM_CH times with a generate loop.
- The FSM, config pointer and max-delay tree stay in the top module.

Test Plan:
- Reset defaults: rst=1 for 1 cycle, then start_transmit with no bytes loaded -> all delays 0; all 8 channels high together for exactly 4 cycles. FIRE lasts 4 cycles, GUARD 2, LISTEN 32 with afe_switch=1, then busy stays 1 in WAIT_CLR.
- Steered profile: load bytes 0,1,2,...,7, then start -> channel i rises i cycles after channel 0, each high for 4 cycles. FIRE lasts 11 cycles. Check afe_switch rises exactly 2 cycles after ch7 falls.
- Full frame: start, then pulse mem_clear 700 ns after each WAIT_CLR entry, 5 times -> line_index steps 0..4. frame_done pulses once after the 5th mem_clear. busy drops the next cycle.
- Ignored events:
  - mem_clear during LISTEN, start_transmit during FIRE, and a byte 0x3F during LISTEN -> no state change and no profile change;
  - a byte of 0xC5 in IDLE stores delay 5 (upper bits dropped).
- Pointer wrap: send 9 bytes (values 10..18) -> ch0 delay=18, ch1..ch7 delays=11..17, cfg_ptr=1.
- Reset mid-FIRE: assert rst while ch3 is high -> next cycle all pulses=0, afe_switch=0, busy=0, delays all 0.
- Invariant checker: assertion active throughout that pulses and afe_switch are never high in the same cycle.
